// File: rtl/if_id_fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction ROM address and
// registers the fetched word plus PC+4 into the IF/ID pipeline register.
module if_id_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h00400000,
    parameter logic [31:0] NOP_WORD = 32'h00000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic [31:0] imem_instr,
    output logic [31:0] imem_addr,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc4,
    output logic        ifid_valid,
    output logic [31:0] fetch_count,
    output logic        misalign
);

    logic [31:0] r_pc;
    logic [31:0] r_ifid_instr;
    logic [31:0] r_ifid_pc4;
    logic        r_ifid_valid;
    logic [31:0] r_fetch_count;
    logic        r_misalign;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_redirect_target;
    logic        w_squash;
    logic        w_load;
    logic        w_bad_target;

    assign w_pc_plus4        = r_pc + 32'd4;
    assign w_redirect_target = {redirect_pc[31:2], 2'b00};
    // A redirect always squashes the wrong-path word sitting at the ROM output.
    assign w_squash          = flush | redirect_valid;
    assign w_load            = ~w_squash & ~stall;
    assign w_bad_target      = redirect_valid & (redirect_pc[1:0] != 2'b00);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc <= RESET_PC;
        end else if (redirect_valid) begin
            r_pc <= w_redirect_target;
        end else if (!stall) begin
            r_pc <= w_pc_plus4;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ifid_instr <= NOP_WORD;
            r_ifid_pc4   <= 32'd0;
            r_ifid_valid <= 1'b0;
        end else if (w_squash) begin
            r_ifid_instr <= NOP_WORD;
            r_ifid_pc4   <= w_pc_plus4;
            r_ifid_valid <= 1'b0;
        end else if (w_load) begin
            r_ifid_instr <= imem_instr;
            r_ifid_pc4   <= w_pc_plus4;
            r_ifid_valid <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fetch_count <= 32'd0;
        end else if (w_load) begin
            r_fetch_count <= r_fetch_count + 32'd1;
        end
    end

    // Sticky until reset so software can inspect it after the fact.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_misalign <= 1'b0;
        end else if (w_bad_target) begin
            r_misalign <= 1'b1;
        end
    end

    assign imem_addr   = r_pc;
    assign ifid_instr  = r_ifid_instr;
    assign ifid_pc4    = r_ifid_pc4;
    assign ifid_valid  = r_ifid_valid;
    assign fetch_count = r_fetch_count;
    assign misalign    = r_misalign;

endmodule
